// File: rtl/seg7_scroll_buffer.sv
// Character FIFO feeding a scrolling seven-segment window. Characters enter
// through valid/ready and shift into digit 0 at a fixed rate; blanks follow when the FIFO is empty.
module seg7_scroll_buffer #(
  parameter int clk_mhz    = 50,
  parameter int w_digit    = 8,
  parameter int scroll_hz  = 5,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          char_valid,
  input  logic [4:0]                    char_code,
  output logic                          char_ready,
  input  logic                          pause,
  input  logic                          clear,
  output logic [w_digit*8-1:0]          patterns,
  output logic                          scroll_tick,
  output logic [$clog2(fifo_depth):0]   fifo_count
);

  localparam int PERIOD = clk_mhz * 1_000_000 / scroll_hz;
  localparam int DIV_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PTR_W  = $clog2(fifo_depth);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PAT_W  = w_digit * 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(fifo_depth);

  // Segment order {a,b,c,d,e,f,g,h}; the decimal point is never lit.
  function automatic logic [7:0] encode(input logic [4:0] code);
    logic [7:0] seg;
    case (code)
      5'h00: seg = 8'hFC;  5'h01: seg = 8'h60;  5'h02: seg = 8'hDA;  5'h03: seg = 8'hF2;
      5'h04: seg = 8'h66;  5'h05: seg = 8'hB6;  5'h06: seg = 8'hBE;  5'h07: seg = 8'hE0;
      5'h08: seg = 8'hFE;  5'h09: seg = 8'hF6;  5'h0A: seg = 8'hEE;  5'h0B: seg = 8'h3E;
      5'h0C: seg = 8'h9C;  5'h0D: seg = 8'h7A;  5'h0E: seg = 8'h9E;  5'h0F: seg = 8'h8E;
      5'h10: seg = 8'hBC;  5'h11: seg = 8'h6E;  5'h12: seg = 8'h1C;  5'h13: seg = 8'hCE;
      5'h14: seg = 8'h0A;  5'h15: seg = 8'h7C;  5'h16: seg = 8'h02;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             tick_q, tick_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [4:0]       mem_q [fifo_depth];

  logic       step_s, push_s, pop_s;
  logic [7:0] dig0_s;

  // Next-state logic: clear overrides everything; a pop only happens on a step with data queued.
  always_comb begin
    step_s   = (div_q == DIV_LAST) && !pause && !clear;
    push_s   = char_valid && ready_q && !clear;
    pop_s    = step_s && (count_q != {CNT_W{1'b0}});
    dig0_s   = pop_s ? encode(mem_q[rd_ptr_q]) : 8'h00;
    div_d    = div_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pat_d    = pat_q;
    tick_d   = step_s;
    if (clear) begin
      div_d    = {DIV_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
      pat_d    = {PAT_W{1'b0}};
    end else begin
      if (pause) begin
        div_d = div_q;
      end else if (div_q == DIV_LAST) begin
        div_d = {DIV_W{1'b0}};
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (step_s) begin
        pat_d = (pat_q << 8) | PAT_W'(dig0_s);
      end else begin
        pat_d = pat_q;
      end
    end
    ready_d = (count_d != CNT_FULL);
  end

  // Control and window state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= {DIV_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      ready_q  <= 1'b1;
      tick_q   <= 1'b0;
      pat_q    <= {PAT_W{1'b0}};
    end else begin
      div_q    <= div_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      tick_q   <= tick_d;
      pat_q    <= pat_d;
    end
  end

  // Character storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < fifo_depth; i++) begin
        mem_q[i] <= 5'h00;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= char_code;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign char_ready  = ready_q;
  assign scroll_tick = tick_q;
  assign patterns    = pat_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_seg7_scroll_buffer.sv
// Scoreboard bench for seg7_scroll_buffer: a queue/array reference model predicts
// each scrolled window, and a monitor compares it whenever scroll_tick is seen.
module tb_seg7_scroll_buffer;

  localparam int WD    = 8;
  localparam int DEPTH = 4;
  localparam int PER   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        char_valid = 1'b0;
  logic [4:0]  char_code = 5'h00;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic        char_ready;
  logic [63:0] patterns;
  logic        scroll_tick;
  logic [2:0]  fifo_count;

  seg7_scroll_buffer #(
    .clk_mhz(1), .w_digit(WD), .scroll_hz(250_000), .fifo_depth(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
    .char_ready(char_ready), .pause(pause), .clear(clear), .patterns(patterns),
    .scroll_tick(scroll_tick), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] enc_tab [0:31] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E,
    8'hBC, 8'h6E, 8'h1C, 8'hCE, 8'h0A, 8'h7C, 8'h02, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  // Reference model state
  logic [4:0]  m_q [$];
  logic [63:0] sb [$];
  logic [63:0] m_win;
  int          m_phase;
  bit          m_step, m_take, m_tick;
  logic [7:0]  m_byte;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: text queue, window as a byte shift register, phase counter modulo PER.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      sb.delete();
      m_win   = 64'h0;
      m_phase = 0;
      m_tick  = 1'b0;
    end else begin
      m_step = (m_phase == PER - 1) && !pause && !clear;
      m_take = char_valid && (m_q.size() < DEPTH);
      m_tick = m_step;
      if (clear) begin
        m_q.delete();
        m_win   = 64'h0;
        m_phase = 0;
      end else begin
        if (m_step) begin
          m_byte = (m_q.size() != 0) ? enc_tab[m_q.pop_front()] : 8'h00;
          m_win  = {m_win[55:0], m_byte};
          sb.push_back(m_win);
        end
        if (m_take) m_q.push_back(char_code);
        if (!pause) m_phase = (m_phase + 1) % PER;
      end
    end
  end

  // Monitor: status every cycle, window contents popped from the scoreboard on each tick.
  always @(negedge clk) begin
    if (rst) begin
      chk("tick", 64'(scroll_tick), 64'(m_tick));
      chk("count", 64'(fifo_count), 64'(m_q.size()));
      chk("ready", 64'(char_ready), 64'(m_q.size() != DEPTH));
      if (scroll_tick) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL window: tick with no expected window queued");
        end else begin
          chk("window", patterns, sb.pop_front());
        end
      end
    end
  end

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scroll_tick && n < budget);
    if (!scroll_tick) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: no scroll_tick within %0d cycles", budget);
    end
  endtask

  task automatic push_one(input logic [4:0] c);
    char_valid = 1'b1;
    char_code  = c;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4:0]  word [4];
    logic [7:0]  unm [3];
    logic [63:0] snap;
    word = '{5'h0F, 5'h13, 5'h10, 5'h0A};
    unm  = '{8'h00, 8'h00, 8'h02};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_patterns", patterns, 64'h0);
    chk("rst_count", 64'(fifo_count), 64'h0);
    chk("rst_ready", 64'(char_ready), 64'h1);
    chk("rst_tick", 64'(scroll_tick), 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // Word entry with backpressure
    pause = 1'b1;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      char_valid = 1'b1;
      char_code  = word[i];
      @(negedge clk);
      chk("fill_count", 64'(fifo_count), 64'(i + 1));
    end
    char_code = 5'h05;
    repeat (3) @(negedge clk);
    chk("full_ready", 64'(char_ready), 64'h0);
    chk("full_count", 64'(fifo_count), 64'h4);
    char_valid = 1'b0;
    pause = 1'b0;
    wait_tick(8, n);
    chk("ready_after_pop", 64'(char_ready), 64'h1);
    chk("count_after_pop", 64'(fifo_count), 64'h3);
    for (int k = 0; k < 3; k++) begin
      wait_tick(8, n);
      chk("tick_interval", 64'(n), 64'h4);
      chk("drain_count", 64'(fifo_count), 64'(2 - k));
    end
    chk("word_low", 64'(patterns[31:0]), 64'h8ECEBCEE);
    chk("word_high", 64'(patterns[63:32]), 64'h0);

    // Drain: blanks scroll in until the window is empty
    for (int k = 0; k < 8; k++) wait_tick(8, n);
    chk("drained", patterns, 64'h0);

    // Pause holds window and divider phase
    push_one(5'h01);
    push_one(5'h02);
    push_one(5'h03);
    wait_tick(8, n);
    @(negedge clk);
    snap  = patterns;
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("pause_tick", 64'(scroll_tick), 64'h0);
      chk("pause_freeze", patterns, snap);
    end
    pause = 1'b0;
    wait_tick(8, n);
    chk("resume_phase", 64'(n), 64'h3);

    // Clear colliding with a step and a push
    push_one(5'h08);
    n = 0;
    while (m_phase != PER - 1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    clear      = 1'b1;
    char_valid = 1'b1;
    char_code  = 5'h07;
    @(negedge clk);
    clear      = 1'b0;
    char_valid = 1'b0;
    chk("clr_patterns", patterns, 64'h0);
    chk("clr_count", 64'(fifo_count), 64'h0);
    chk("clr_tick", 64'(scroll_tick), 64'h0);
    wait_tick(8, n);
    chk("clr_next_step", 64'(n), 64'h4);

    // Unmapped codes and the dash
    pause = 1'b1;
    do_clear();
    push_one(5'h17);
    push_one(5'h1F);
    push_one(5'h16);
    pause = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_tick(8, n);
      chk("unmapped_digit0", 64'(patterns[7:0]), 64'(unm[k]));
    end
    chk("unmapped_window", patterns, 64'h0000_0000_0000_0002);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      char_valid = 1'($urandom % 2);
      char_code  = 5'($urandom);
      pause      = ($urandom % 10) == 0;
      clear      = ($urandom % 50) == 0;
      @(negedge clk);
    end
    char_valid = 1'b0;
    pause      = 1'b0;
    clear      = 1'b0;

    // Asynchronous reset in the middle of scrolling
    push_one(5'h08);
    push_one(5'h08);
    wait_tick(8, n);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_patterns", patterns, 64'h0);
    chk("midrst_count", 64'(fifo_count), 64'h0);
    chk("midrst_ready", 64'(char_ready), 64'h1);
    chk("midrst_tick", 64'(scroll_tick), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scroll_buffer.md
Name: seg7_scroll_buffer

Overview:
- Upstream feeder for the dynamic seven-segment scanner.
- Accepts character codes through a valid/ready handshake and queues them in a small FIFO.
- Encodes each character to a segment pattern and scrolls it into a w_digit-wide display window at a fixed rate.
- The window goes out as a flat pattern bus; the scanner multiplexes it onto abcdefgh/digit.

Parameters:
- clk_mhz, 50: system clock frequency in MHz.
- w_digit, 8: number of display positions in the window.
- scroll_hz, 5: scroll steps per second.
- fifo_depth, 4: character FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- char_valid  input  1  char_code is valid this cycle.
- char_code  input  5  character code; map is given under Behaviour.
- char_ready  output  1  FIFO can accept a character.
- pause  input  1  freeze scrolling while high.
- clear  input  1  synchronous flush of FIFO and window.
- patterns  output  w_digit*8  patterns[8*i +: 8] drives digit i; digit 0 is rightmost. Format {a,b,c,d,e,f,g,h}.
- scroll_tick  output  1  one-cycle pulse in the cycle the window shifts.
- fifo_count  output  $clog2(fifo_depth)+1  entries currently queued.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0:
  - patterns=0 (all blank), fifo_count=0, scroll_tick=0, char_ready=1, divider=0.
- Divider:
  - PERIOD = clk_mhz*1_000_000/scroll_hz cycles.
  - Counter runs 0..PERIOD-1 and wraps.
  - step is asserted when counter==PERIOD-1 and pause=0.
  - pause=1 holds the counter value; no step occurs.
- Handshake:
  - char_ready = (fifo_count != fifo_depth).
  - A push happens when char_valid & char_ready.
  - char_code is sampled on the accepting edge.
  - When full, char_valid is ignored; the producer holds the character.
- Step (registered, takes effect on the edge where step=1):
  - Window shifts left: digit i+1 <= digit i for i=0..w_digit-2. The old digit w_digit-1 is discarded.
  - Digit 0 <= encode(FIFO head) and the head is popped when fifo_count != 0.
  - Digit 0 <= blank (8'h00) when the FIFO is empty, so text scrolls off.
  - scroll_tick=1 for exactly the following cycle; patterns changes on that same edge.
- Simultaneous push and pop in one cycle:
  - fifo_count is unchanged.
  - A push into an empty FIFO on a step cycle does not bypass. Blank is shifted and the new character stays queued.
  - Push at full is impossible because char_ready=0. The slot frees on the cycle after the pop.
- clear=1 has priority over step and push:
  - FIFO emptied and window blanked, effective next edge.
  - Divider reset to 0; no scroll_tick.
  - char_valid is ignored that cycle.
- Encoding (5-bit code -> {a..h}):
  - 00..09 = digits 0-9: FC, 60, DA, F2, 66, B6, BE, E0, FE, F6.
  - 0A A=EE, 0B b=3E, 0C C=9C, 0D d=7A, 0E E=9E, 0F F=8E.
  - 10 G=BC, 11 H=6E, 12 L=1C, 13 P=CE, 14 r=0A, 15 U=7C, 16 '-'=02.
  - 17..1F = blank 00.
  - h (decimal point) is never set.
- Pointers: read and write pointers wrap modulo fifo_depth; fifo_count ranges 0..fifo_depth.
- Reset mid-operation: everything returns to reset values immediately; no partial shift.

Test Plan:
- Bench parameters for all scenarios: clk_mhz=1, scroll_hz=250_000, giving PERIOD=4.
- Reset: drive rst=0 mid-scroll -> patterns=0, fifo_count=0, char_ready=1 without waiting for a clock edge.
- Word entry: push 0F,13,10,0A (F,P,G,A), w_digit=8, then wait 4 steps:
  - patterns[31:0]=32'h8ECEBCEE.
  - Upper bytes are 0.
  - One scroll_tick per 4 cycles.
  - fifo_count decrements 4->0.
- Backpressure: hold char_valid=1 with no steps (pause=1):
  - After 4 accepts, char_ready=0 and fifo_count=4.
  - Release pause -> char_ready returns 1 the cycle after the first pop.
- Drain: after the word is loaded, keep stepping with an empty FIFO:
  - Each step shifts 00 in.
  - After 8 further steps, patterns=0.
- Pause: assert pause for 10 cycles mid-scroll -> no scroll_tick and patterns frozen. Scrolling resumes with the held divider phase.
- Clear collision: assert clear on the same cycle as step and char_valid:
  - Next cycle patterns=0, fifo_count=0, scroll_tick=0.
  - Next step occurs 4 cycles later.
- Unmapped codes: push 17 and 1F and 16 -> bytes 00, 00, 02 appear in order at digit 0.
